// File: rtl/simon_sequencer.sv
// Simon-Says round scheduler: grows a pseudo-random colour pattern, replays it on
// the display and checks player presses. All game timing is in prescaler ticks.
module simon_sequencer #(
  parameter int          MAX_LEN       = 16,
  parameter int          COLOR_BITS    = 2,
  parameter int          SHOW_TICKS    = 30,
  parameter int          GAP_TICKS     = 10,
  parameter int          INPUT_TIMEOUT = 250,
  parameter int          BUZZ_TICKS    = 60,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5,
  localparam int         LVL_W         = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  btn_valid,
  input  logic [COLOR_BITS-1:0] btn_color,
  output logic                  show_valid,
  output logic [COLOR_BITS-1:0] show_color,
  output logic [LVL_W-1:0]      level,
  output logic [7:0]            score,
  output logic                  busy,
  output logic                  buzzer,
  output logic                  fail,
  output logic                  win,
  output logic [2:0]            dbg_state
);

  localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TM1  = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int TM2  = (INPUT_TIMEOUT > BUZZ_TICKS) ? INPUT_TIMEOUT : BUZZ_TICKS;
  localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_ROUND_OK, S_FAIL, S_WIN
  } state_e;

  state_e                  state_q, state_d;
  logic [LVL_W-1:0]        level_q, level_d;
  logic [LVL_W-1:0]        idx_q, idx_d;
  logic [7:0]              score_q, score_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;
  logic                    fail_q, fail_d;
  logic                    win_q, win_d;
  logic [7:0]              lfsr_q, lfsr_d;
  logic                    mem_we;
  logic [COLOR_BITS-1:0]   mem_q [MAX_LEN];
  logic [COLOR_BITS-1:0]   mem_rd;
  logic                    last;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1; free-runs every clock.
  assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  assign mem_rd = mem_q[idx_q[AW-1:0]];
  assign last   = (idx_q == level_q - LVL_W'(1));

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    idx_d   = idx_q;
    score_d = score_q;
    fail_d  = fail_q;
    win_d   = win_q;
    mem_we  = 1'b0;
    tcnt_d  = tick ? tcnt_q + 1'b1 : tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ADD;
          level_d = '0;
          score_d = '0;
          fail_d  = 1'b0;
          win_d   = 1'b0;
        end
      end
      S_ADD: begin
        mem_we  = 1'b1;
        level_d = level_q + 1'b1;
        idx_d   = '0;
        state_d = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (tick && tcnt_q == TW'(SHOW_TICKS - 1)) state_d = S_SHOW_OFF;
      end
      S_SHOW_OFF: begin
        if (tick && tcnt_q == TW'(GAP_TICKS - 1)) begin
          if (last) begin
            idx_d   = '0;
            state_d = S_WAIT_IN;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_SHOW_ON;
          end
        end
      end
      S_WAIT_IN: begin
        // A press on the same clock as a tick pre-empts the timeout.
        if (btn_valid) begin
          if (btn_color == mem_rd) begin
            tcnt_d = '0;
            if (last) state_d = S_ROUND_OK;
            else      idx_d   = idx_q + 1'b1;
          end else begin
            state_d = S_FAIL;
          end
        end else if (tick && tcnt_q == TW'(INPUT_TIMEOUT - 1)) begin
          state_d = S_FAIL;
        end
      end
      S_ROUND_OK: begin
        if (score_q != 8'hFF) score_d = score_q + 8'd1;
        state_d = (level_q == LVL_W'(MAX_LEN)) ? S_WIN : S_ADD;
      end
      S_FAIL: begin
        if (tick && tcnt_q == TW'(BUZZ_TICKS - 1)) state_d = S_IDLE;
      end
      S_WIN: begin
        win_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_FAIL && state_q != S_FAIL) fail_d = 1'b1;
    if (state_d != state_q) tcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      level_q <= '0;
      idx_q   <= '0;
      score_q <= '0;
      tcnt_q  <= '0;
      fail_q  <= 1'b0;
      win_q   <= 1'b0;
      lfsr_q  <= SEED;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      idx_q   <= idx_d;
      score_q <= score_d;
      tcnt_q  <= tcnt_d;
      fail_q  <= fail_d;
      win_q   <= win_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Pattern storage needs no reset: only entries below level are ever read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[level_q[AW-1:0]] <= lfsr_q[COLOR_BITS-1:0];
  end

  assign show_valid = (state_q == S_SHOW_ON);
  assign show_color = show_valid ? mem_rd : '0;
  assign level      = level_q;
  assign score      = score_q;
  assign busy       = (state_q != S_IDLE);
  assign buzzer     = (state_q == S_FAIL);
  assign fail       = fail_q;
  assign win        = win_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// Bench for simon_sequencer: directed game scenarios, a reference LFSR feeding an
// expected-colour queue, and a monitor that checks every replayed colour and its timing.
module tb_simon_sequencer;
  localparam int MAX_LEN = 3;
  localparam int SHOW_T  = 2;
  localparam int GAP_T   = 1;
  localparam int TOUT_T  = 4;
  localparam int BUZZ_T  = 3;
  localparam int LW      = $clog2(MAX_LEN + 1);

  localparam logic [2:0] ST_IDLE = 3'd0, ST_ADD = 3'd1, ST_SHOW_ON = 3'd2, ST_SHOW_OFF = 3'd3,
                         ST_WAIT_IN = 3'd4, ST_ROUND_OK = 3'd5, ST_FAIL = 3'd6, ST_WIN = 3'd7;

  logic          clk = 1'b0, reset = 1'b1, tick = 1'b0, start = 1'b0, btn_valid = 1'b0;
  logic [1:0]    btn_color = 2'd0;
  logic          show_valid, busy, buzzer, fail, win;
  logic [1:0]    show_color;
  logic [LW-1:0] level;
  logic [7:0]    score;
  logic [2:0]    dbg_state;

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];
  logic [1:0] exp_pat[MAX_LEN];
  int         exp_len = 0;
  logic [7:0] m_lfsr;

  simon_sequencer #(
    .MAX_LEN(MAX_LEN), .COLOR_BITS(2), .SHOW_TICKS(SHOW_T), .GAP_TICKS(GAP_T),
    .INPUT_TIMEOUT(TOUT_T), .BUZZ_TICKS(BUZZ_T), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .btn_valid(btn_valid),
    .btn_color(btn_color), .show_valid(show_valid), .show_color(show_color),
    .level(level), .score(score), .busy(busy), .buzzer(buzzer), .fail(fail),
    .win(win), .dbg_state(dbg_state)
  );

  // ---------------- clock / tick / reset model ----------------
  always #5 clk = ~clk;

  initial begin
    int tc = 0;
    forever begin
      @(posedge clk);
      #1;
      tc   = (tc + 1) % 4;
      tick = (tc == 0);
    end
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    logic fb;
    fb = s[0];
    s  = s >> 1;
    if (fb) s = s ^ 8'b1011_1000;
    return s;
  endfunction

  always @(posedge clk) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic prev_sv = 1'b0, prev_off = 1'b0;
  int   on_ticks = 0, off_ticks = 0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_len   = 0;
      prev_sv   = 1'b0;
      prev_off  = 1'b0;
      on_ticks  = 0;
      off_ticks = 0;
    end else begin
      if (dbg_state == ST_IDLE) exp_len = 0;
      if (dbg_state == ST_ADD && exp_len < MAX_LEN) begin
        exp_pat[exp_len] = m_lfsr[1:0];
        exp_len++;
        for (int i = 0; i < exp_len; i++) exp_q.push_back(exp_pat[i]);
      end
      if (show_valid && !prev_sv) begin
        on_ticks = 0;
        if (exp_q.size() == 0) check("show_unexpected", 1, 0);
        else check("show_color", show_color, exp_q.pop_front());
      end
      if (!show_valid && prev_sv) begin
        check("show_ticks", on_ticks, SHOW_T);
        check("dark_color", show_color, 0);
      end
      if (show_valid && tick) on_ticks++;
      if (dbg_state == ST_SHOW_OFF && !prev_off) off_ticks = 0;
      if (dbg_state != ST_SHOW_OFF && prev_off) check("gap_ticks", off_ticks, GAP_T);
      if (dbg_state == ST_SHOW_OFF && tick) off_ticks++;
      prev_sv  = show_valid;
      prev_off = (dbg_state == ST_SHOW_OFF);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input string name);
    int k = 0;
    while (dbg_state != st && k < 500) begin
      step();
      k++;
    end
    check(name, dbg_state, st);
  endtask

  task automatic press(input logic [1:0] c);
    btn_valid = 1'b1;
    btn_color = c;
    step();
    btn_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Presses the whole pattern; returns one clock after the final press.
  task automatic play_round();
    int n;
    wait_state(ST_WAIT_IN, "reach_wait_in");
    n = exp_len;
    for (int i = 0; i < n; i++) begin
      press(exp_pat[i]);
      if (i < n - 1) step(2);
    end
  endtask

  // Leaves the bench positioned on the clock whose upcoming edge is the 4th WAIT_IN tick.
  task automatic seek_fourth_tick();
    int nt = 0;
    int k  = 0;
    while (k < 100) begin
      if (tick) nt++;
      if (nt == 4) break;
      step();
      k++;
    end
    check("fourth_tick_found", nt, 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    step(3);
    reset = 1'b0;
    step();
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_level", level, 0);
    check("rst_score", score, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {buzzer, fail, win, show_valid}, 0);

    // 1: reset in the middle of playback, then presses in IDLE
    pulse_start();
    wait_state(ST_SHOW_ON, "t1_show_on");
    step(2);
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("t1_state", dbg_state, ST_IDLE);
    check("t1_show_valid", show_valid, 0);
    check("t1_busy", busy, 0);
    check("t1_level", level, 0);
    press(2'd1);
    step();
    press(2'd2);
    step(2);
    check("t1_idle_btn_state", dbg_state, ST_IDLE);
    check("t1_idle_btn_level", level, 0);
    check("t1_idle_btn_score", score, 0);

    // 2: first round timing and a correct press
    pulse_start();
    check("t2_add", dbg_state, ST_ADD);
    check("t2_add_level", level, 0);
    step();
    check("t2_show_on", dbg_state, ST_SHOW_ON);
    check("t2_level1", level, 1);
    check("t2_show_valid", show_valid, 1);
    play_round();
    check("t2_round_ok", dbg_state, ST_ROUND_OK);
    step();
    check("t2_score", score, 1);
    step();
    check("t2_level2", level, 2);

    // 3: finish the game with a win, then restart
    play_round();
    check("t3_round_ok2", dbg_state, ST_ROUND_OK);
    play_round();
    check("t3_round_ok3", dbg_state, ST_ROUND_OK);
    step();
    check("t3_win_state", dbg_state, ST_WIN);
    step();
    check("t3_idle", dbg_state, ST_IDLE);
    check("t3_win", win, 1);
    check("t3_busy", busy, 0);
    check("t3_score", score, 3);
    check("t3_level", level, 3);
    check("t3_queue_drained", exp_q.size(), 0);
    pulse_start();
    check("t3_win_clr", win, 0);
    check("t3_score_clr", score, 0);
    check("t3_level_clr", level, 0);

    // 4: wrong second press at level 2
    play_round();
    check("t4_round_ok", dbg_state, ST_ROUND_OK);
    wait_state(ST_WAIT_IN, "t4_wait_in");
    check("t4_level", level, 2);
    press(exp_pat[0]);
    step();
    press(exp_pat[1] + 2'd1);
    check("t4_fail_state", dbg_state, ST_FAIL);
    check("t4_fail", fail, 1);
    check("t4_buzzer", buzzer, 1);
    begin
      int bt = 0;
      int k  = 0;
      while (dbg_state == ST_FAIL && k < 200) begin
        if (tick) bt++;
        step();
        k++;
      end
      check("t4_buzz_ticks", bt, BUZZ_T);
    end
    check("t4_idle", dbg_state, ST_IDLE);
    check("t4_buzzer_off", buzzer, 0);
    check("t4_fail_sticky", fail, 1);
    check("t4_score", score, 1);

    // 5a: no press, timeout on the 4th tick
    pulse_start();
    check("t5_fail_clr", fail, 0);
    wait_state(ST_WAIT_IN, "t5a_wait_in");
    seek_fourth_tick();
    check("t5a_no_early_timeout", dbg_state, ST_WAIT_IN);
    step();
    check("t5a_timeout", dbg_state, ST_FAIL);
    wait_state(ST_IDLE, "t5a_back_idle");

    // 5b: press coincident with the 4th tick wins over the timeout
    pulse_start();
    wait_state(ST_WAIT_IN, "t5b_wait_in");
    seek_fourth_tick();
    btn_valid = 1'b1;
    btn_color = exp_pat[0];
    step();
    btn_valid = 1'b0;
    check("t5b_press_wins", dbg_state, ST_ROUND_OK);
    check("t5b_no_fail", fail, 0);

    // 6: start and presses during playback are ignored
    wait_state(ST_SHOW_ON, "t6_show_on");
    pulse_start();
    press(2'd3);
    check("t6_level_on", level, 2);
    wait_state(ST_SHOW_OFF, "t6_show_off");
    pulse_start();
    press(2'd0);
    check("t6_level_off", level, 2);
    check("t6_busy", busy, 1);
    wait_state(ST_WAIT_IN, "t6_wait_in");
    check("t6_level_wait", level, 2);
    check("t6_queue_drained", exp_q.size(), 0);
    play_round();
    check("t6_round_ok", dbg_state, ST_ROUND_OK);
    step();
    check("t6_score", score, 2);

    step(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
